// File: rtl/digit_entry_buffer.sv
// Keypad number-entry buffer: collects decimal keypresses into a packed BCD word
// with sign, backspace and clear, and hands the committed number off via valid/ready.
module digit_entry_buffer #(
    parameter int         NUM_DIGITS = 4,
    parameter logic [3:0] KEY_BKSP   = 4'hB,
    parameter logic [3:0] KEY_SIGN   = 4'hD,
    parameter logic [3:0] KEY_CLEAR  = 4'hC,
    parameter logic [3:0] KEY_ENTER  = 4'hE
) (
    input  logic                              clk,
    input  logic                              nrst,
    input  logic                              keystrobe,
    input  logic [3:0]                        keycode,
    output logic [4*NUM_DIGITS-1:0]           entry_bcd,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   entry_cnt,
    output logic                              entry_neg,
    output logic [4*NUM_DIGITS-1:0]           num_bcd,
    output logic                              num_neg,
    output logic                              num_valid,
    input  logic                              num_ready,
    output logic                              overflow
);

    localparam int BW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(NUM_DIGITS);

    typedef enum logic {
        ENTRY = 1'b0,
        PEND  = 1'b1
    } state_t;

    state_t state;

    logic is_digit;
    logic buf_full;
    logic buf_empty;

    assign is_digit  = (keycode < 4'd10);
    assign buf_full  = (entry_cnt == CNT_MAX);
    assign buf_empty = (entry_cnt == '0);

    // Shift the new digit in at the LS nibble; the top nibble is known empty here.
    function automatic logic [BW-1:0] push_digit(input logic [BW-1:0] word,
                                                 input logic [3:0]    d);
        return (word << 4) | BW'(d);
    endfunction

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= ENTRY;
            entry_bcd <= '0;
            entry_cnt <= '0;
            entry_neg <= 1'b0;
            num_bcd   <= '0;
            num_neg   <= 1'b0;
            num_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            overflow <= 1'b0;
            case (state)
                ENTRY: begin
                    if (keystrobe) begin
                        if (is_digit) begin
                            if (buf_full) begin
                                overflow <= 1'b1;
                            end else if (!(keycode == 4'd0 && buf_empty)) begin
                                entry_bcd <= push_digit(entry_bcd, keycode);
                                entry_cnt <= entry_cnt + CW'(1);
                            end
                        end else if (keycode == KEY_BKSP) begin
                            if (!buf_empty) begin
                                entry_bcd <= entry_bcd >> 4;
                                entry_cnt <= entry_cnt - CW'(1);
                                // Removing the last digit leaves nothing to carry a sign.
                                if (entry_cnt == CW'(1)) begin
                                    entry_neg <= 1'b0;
                                end
                            end
                        end else if (keycode == KEY_SIGN) begin
                            if (!buf_empty) begin
                                entry_neg <= ~entry_neg;
                            end
                        end else if (keycode == KEY_CLEAR) begin
                            entry_bcd <= '0;
                            entry_cnt <= '0;
                            entry_neg <= 1'b0;
                        end else if (keycode == KEY_ENTER) begin
                            num_bcd   <= entry_bcd;
                            num_neg   <= entry_neg;
                            num_valid <= 1'b1;
                            entry_bcd <= '0;
                            entry_cnt <= '0;
                            entry_neg <= 1'b0;
                            state     <= PEND;
                        end
                    end
                end
                PEND: begin
                    // Keys are dropped while waiting; committed value stays for the consumer.
                    if (num_ready) begin
                        num_valid <= 1'b0;
                        state     <= ENTRY;
                    end
                end
                default: state <= ENTRY;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_entry_buffer.sv
// Bench for digit_entry_buffer: directed scenarios plus randomized keys against a
// digit-queue reference model, compared every cycle on the falling edge.
module tb_digit_entry_buffer;

    localparam int N  = 4;
    localparam int BW = 4 * N;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          keystrobe = 1'b0;
    logic [3:0]    keycode = 4'h0;
    logic          num_ready = 1'b0;
    logic [BW-1:0] entry_bcd;
    logic [CW-1:0] entry_cnt;
    logic          entry_neg;
    logic [BW-1:0] num_bcd;
    logic          num_neg;
    logic          num_valid;
    logic          overflow;

    digit_entry_buffer #(.NUM_DIGITS(N)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .keystrobe (keystrobe),
        .keycode   (keycode),
        .entry_bcd (entry_bcd),
        .entry_cnt (entry_cnt),
        .entry_neg (entry_neg),
        .num_bcd   (num_bcd),
        .num_neg   (num_neg),
        .num_valid (num_valid),
        .num_ready (num_ready),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: digits in entry order, most significant first.
    int  m_dig[$];
    bit  m_neg;
    bit  m_pend;
    int  m_num;
    bit  m_num_neg;
    bit  m_ovf;

    function automatic int model_bcd();
        int v = 0;
        foreach (m_dig[i]) v = v * 16 + m_dig[i];
        return v;
    endfunction

    task automatic model_reset();
        m_dig.delete();
        m_neg = 0; m_pend = 0; m_num = 0; m_num_neg = 0; m_ovf = 0;
    endtask

    task automatic model_step(input bit ks, input int kc, input bit rdy);
        m_ovf = 0;
        if (m_pend) begin
            if (rdy) m_pend = 0;
        end else if (ks) begin
            if (kc < 10) begin
                if (m_dig.size() == N) m_ovf = 1;
                else if (!(kc == 0 && m_dig.size() == 0)) m_dig.push_back(kc);
            end else if (kc == 'hB) begin
                if (m_dig.size() > 0) void'(m_dig.pop_back());
                if (m_dig.size() == 0) m_neg = 0;
            end else if (kc == 'hD) begin
                if (m_dig.size() > 0) m_neg = !m_neg;
            end else if (kc == 'hC) begin
                m_dig.delete(); m_neg = 0;
            end else if (kc == 'hE) begin
                m_num = model_bcd(); m_num_neg = m_neg; m_pend = 1;
                m_dig.delete(); m_neg = 0;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("entry_bcd", 32'(entry_bcd), 32'(model_bcd()));
        chk("entry_cnt", 32'(entry_cnt), 32'(m_dig.size()));
        chk("entry_neg", 32'(entry_neg), 32'(m_neg));
        chk("num_valid", 32'(num_valid), 32'(m_pend));
        chk("num_bcd",   32'(num_bcd),   32'(m_num));
        chk("num_neg",   32'(num_neg),   32'(m_num_neg));
        chk("overflow",  32'(overflow),  32'(m_ovf));
    endtask

    // Called at a falling edge: drive inputs, advance model, check at next falling edge.
    task automatic cycle(input bit ks, input int kc, input bit rdy);
        keystrobe = ks;
        keycode   = 4'(kc);
        num_ready = rdy;
        model_step(ks, kc, rdy);
        @(negedge clk);
        compare_all();
    endtask

    task automatic key(input int kc, input bit rdy);
        cycle(1'b1, kc, rdy);
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, 0, rdy);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2 nrst = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        nrst = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        chk("reset_num_valid", 32'(num_valid), 32'h0);
        chk("reset_entry_bcd", 32'(entry_bcd), 32'h0);
        nrst = 1'b1;

        // 1,2,3,ENTER with ready high
        key(1, 1); key(2, 1); key(3, 1);
        chk("t1_entry_bcd", 32'(entry_bcd), 32'h0123);
        chk("t1_entry_cnt", 32'(entry_cnt), 32'd3);
        key('hE, 1);
        chk("t1_num_valid", 32'(num_valid), 32'h1);
        chk("t1_num_bcd", 32'(num_bcd), 32'h0123);
        chk("t1_cleared", 32'(entry_cnt), 32'd0);
        idle(1);
        chk("t1_handshake", 32'(num_valid), 32'h0);
        chk("t1_retained", 32'(num_bcd), 32'h0123);

        // Leading zeros dropped
        key(0, 0); key(0, 0); key(7, 0);
        chk("t2_entry_bcd", 32'(entry_bcd), 32'h0007);
        chk("t2_entry_cnt", 32'(entry_cnt), 32'd1);
        key('hC, 0);

        // Overflow on fifth digit
        key(9, 0); key(8, 0); key(7, 0); key(6, 0); key(5, 0);
        chk("t3_entry_bcd", 32'(entry_bcd), 32'h9876);
        chk("t3_entry_cnt", 32'(entry_cnt), 32'd4);
        chk("t3_overflow", 32'(overflow), 32'h1);
        idle(0);
        chk("t3_overflow_end", 32'(overflow), 32'h0);
        key('hC, 0);

        // Sign ignored at zero digits; backspace then negative commit
        key('hD, 0);
        chk("t4_sign_empty", 32'(entry_neg), 32'h0);
        key(4, 0); key(2, 0); key('hB, 0); key('hD, 0);
        chk("t4_entry_neg", 32'(entry_neg), 32'h1);
        key('hE, 0);
        chk("t4_num_bcd", 32'(num_bcd), 32'h0004);
        chk("t4_num_neg", 32'(num_neg), 32'h1);
        idle(1);
        chk("t4_handshake", 32'(num_valid), 32'h0);

        // Backspace to empty clears sign
        key(6, 0); key('hD, 0); key('hB, 0);
        chk("t5_bksp_sign", 32'(entry_neg), 32'h0);

        // Held pending number: keys dropped, key with handshake dropped
        key(5, 0); key('hE, 0);
        key(3, 0); idle(0); key('hC, 0); idle(0); key(9, 0);
        chk("t6_held_valid", 32'(num_valid), 32'h1);
        chk("t6_held_bcd", 32'(num_bcd), 32'h0005);
        chk("t6_keys_dropped", 32'(entry_cnt), 32'd0);
        key(7, 1);
        chk("t6_hs_key_dropped", 32'(entry_cnt), 32'd0);
        chk("t6_hs_valid", 32'(num_valid), 32'h0);

        // Empty ENTER commits zero
        key('hE, 0);
        chk("t7_zero_commit", 32'(num_valid), 32'h1);
        chk("t7_zero_bcd", 32'(num_bcd), 32'h0);
        idle(1);

        // Async reset mid-PEND
        key(8, 0); key('hE, 0); idle(0);
        async_reset();
        chk("t8_rst_valid", 32'(num_valid), 32'h0);
        chk("t8_rst_bcd", 32'(num_bcd), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            int kc;
            r = $urandom_range(0, 99);
            if (r < 60) kc = $urandom_range(0, 9);
            else kc = $urandom_range(10, 15);
            if ($urandom_range(0, 599) == 0) async_reset();
            else cycle(($urandom_range(0, 2) != 0), kc, ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
